// File: rtl/seq_add64_pkg.sv
// Shared definitions for the seq_add64 multi-cycle adder.
//   state_t      : FSM state encoding (IDLE/LO/HI/DONE)
//   HALF_W       : width of one half of the 64-bit operands
//   add_ovf()    : signed-overflow rule for an addition given the MSBs
package seq_add64_pkg;

  localparam int HALF_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Signed overflow: both addends share a sign and the result sign differs.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic s_msb);
    return (a_msb == b_msb) & (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/seq_add64_rca32.sv
// RCA_32bit: 32-bit ripple-carry adder, purely combinational.
//   a, b : 32-bit addends
//   cin  : carry into bit 0
//   sum  : 32-bit sum
//   cout : carry out of bit 31
module RCA_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] carry_s;

  // Full-adder chain, bit 0 to bit 31.
  always_comb begin
    carry_s    = 33'd0;
    sum        = 32'd0;
    carry_s[0] = cin;
    for (int i = 0; i < 32; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = carry_s[32];

endmodule

// File: rtl/seq_add64.sv
// seq_add64: 64-bit add/subtract computed over two cycles on one RCA_32bit.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (a, b, sub)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
//   sum                 : registered 64-bit result
//   cout                : carry out of bit 63 (subtract: 1 = no borrow)
//   ovf                 : signed overflow
// Parameter SUB_EN: 1 honours sub, 0 forces every operation to an add.
module seq_add64
  import seq_add64_pkg::*;
#(
  parameter bit SUB_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] sum,
  output logic        cout,
  output logic        ovf
);

  state_t                state_r;
  logic   [63:0]         a_r;
  logic   [63:0]         b_r;
  logic                  op_r;
  logic                  c_r;

  logic   [HALF_W-1:0]   add_a_s;
  logic   [HALF_W-1:0]   add_b_s;
  logic                  add_cin_s;
  logic   [HALF_W-1:0]   add_sum_s;
  logic                  add_cout_s;
  logic                  accept_s;

  // A finished result may be replaced in the same cycle it is consumed.
  assign in_ready = (state_r == IDLE) | ((state_r == DONE) & out_ready);
  assign accept_s = in_valid & in_ready;

  // Steer one operand half into the shared adder; subtract uses ~b + 1.
  always_comb begin
    add_a_s   = {HALF_W{1'b0}};
    add_b_s   = {HALF_W{1'b0}};
    add_cin_s = 1'b0;
    case (state_r)
      LO: begin
        add_a_s   = a_r[HALF_W-1:0];
        add_b_s   = b_r[HALF_W-1:0] ^ {HALF_W{op_r}};
        add_cin_s = op_r;
      end
      HI: begin
        add_a_s   = a_r[63:HALF_W];
        add_b_s   = b_r[63:HALF_W] ^ {HALF_W{op_r}};
        add_cin_s = c_r;
      end
      default: begin
        add_a_s   = {HALF_W{1'b0}};
        add_b_s   = {HALF_W{1'b0}};
        add_cin_s = 1'b0;
      end
    endcase
  end

  RCA_32bit u_rca (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (add_cin_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Sequencing FSM plus operand, carry and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      a_r       <= 64'd0;
      b_r       <= 64'd0;
      op_r      <= 1'b0;
      c_r       <= 1'b0;
      sum       <= 64'd0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          out_valid <= 1'b0;
          if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            op_r    <= sub & SUB_EN;
            state_r <= LO;
          end else begin
            state_r <= IDLE;
          end
        end
        LO: begin
          sum[HALF_W-1:0] <= add_sum_s;
          c_r             <= add_cout_s;
          state_r         <= HI;
        end
        HI: begin
          sum[63:HALF_W] <= add_sum_s;
          cout           <= add_cout_s;
          // add_b_s[HALF_W-1] is bit 63 of the (possibly inverted) b operand.
          ovf            <= add_ovf(a_r[63], add_b_s[HALF_W-1], add_sum_s[HALF_W-1]);
          out_valid      <= 1'b1;
          state_r        <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              a_r     <= a;
              b_r     <= b;
              op_r    <= sub & SUB_EN;
              state_r <= LO;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_add64.sv
module tb_seq_add64;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        sub;

  logic        in_ready,  out_valid,  cout,  ovf;
  logic [63:0] sum;
  logic        in_ready_n, out_valid_n, cout_n, ovf_n;
  logic [63:0] sum_n;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  seq_add64 #(.SUB_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  seq_add64 #(.SUB_EN(1'b0)) dut_add (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_n),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid_n), .out_ready(out_ready),
    .sum(sum_n), .cout(cout_n), .ovf(ovf_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation from IDLE, wait for the result, capture it, consume it.
  task automatic run_op(input logic [63:0] av, input logic [63:0] bv, input logic sv,
                        output logic [63:0] rs, output logic rc, output logic ro,
                        output logic [63:0] rsn, output logic rcn, output logic ron,
                        output int lat);
    a = av; b = bv; sub = sv; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    rs = sum; rc = cout; ro = ovf; rsn = sum_n; rcn = cout_n; ron = ovf_n;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 64'd0; b = 64'd0; sub = 1'b0;
    step(); step();
    rst = 1'b0;
    tests++;
    if ({out_valid, in_ready, cout, ovf, sum} !== {1'b0, 1'b1, 1'b0, 1'b0, 64'd0}) begin
      failed++;
      $display("FAIL reset: ov/ir/c/o/sum=%b%b%b%b %h expected 0100 0", out_valid, in_ready, cout, ovf, sum);
    end
    tests++;
    if ({out_valid_n, in_ready_n} !== 2'b01) begin
      failed++;
      $display("FAIL reset_addonly: ov/ir=%b%b expected 01", out_valid_n, in_ready_n);
    end
  endtask

  task automatic test_carry_cross();
    logic [63:0] rs, rsn; logic rc, ro, rcn, ron; int lat;
    run_op(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, rs, rc, ro, rsn, rcn, ron, lat);
    tests++;
    if (lat !== 3) begin
      failed++; $display("FAIL latency: got %0d expected 3", lat);
    end
    tests++;
    if ({rc, ro, rs} !== {1'b0, 1'b0, 64'h0000_0001_0000_0000}) begin
      failed++; $display("FAIL carry_cross: c=%b o=%b sum=%h expected c=0 o=0 sum=0000000100000000", rc, ro, rs);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] rs, rsn; logic rc, ro, rcn, ron; int lat;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, rs, rc, ro, rsn, rcn, ron, lat);
    tests++;
    if ({rc, ro, rs} !== {1'b1, 1'b0, 64'd0}) begin
      failed++; $display("FAIL wrap: c=%b o=%b sum=%h expected c=1 o=0 sum=0", rc, ro, rs);
    end
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, rs, rc, ro, rsn, rcn, ron, lat);
    tests++;
    if ({rc, ro, rs} !== {1'b0, 1'b1, 64'h8000_0000_0000_0000}) begin
      failed++; $display("FAIL signed_ovf: c=%b o=%b sum=%h expected c=0 o=1 sum=8000000000000000", rc, ro, rs);
    end
  endtask

  task automatic test_sub();
    logic [63:0] rs, rsn; logic rc, ro, rcn, ron; int lat;
    run_op(64'd5, 64'd7, 1'b1, rs, rc, ro, rsn, rcn, ron, lat);
    tests++;
    if ({rc, ro, rs} !== {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE}) begin
      failed++; $display("FAIL sub: c=%b o=%b sum=%h expected c=0 o=0 sum=fffffffffffffffe", rc, ro, rs);
    end
    tests++;
    if ({rcn, ron, rsn} !== {1'b0, 1'b0, 64'd12}) begin
      failed++; $display("FAIL sub_disabled: c=%b o=%b sum=%h expected c=0 o=0 sum=c", rcn, ron, rsn);
    end
    run_op(64'd9, 64'd4, 1'b1, rs, rc, ro, rsn, rcn, ron, lat);
    tests++;
    if ({rc, ro, rs} !== {1'b1, 1'b0, 64'd5}) begin
      failed++; $display("FAIL sub_noborrow: c=%b o=%b sum=%h expected c=1 o=0 sum=5", rc, ro, rs);
    end
  endtask

  task automatic test_back_to_back();
    a = 64'd10; b = 64'd20; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step(); step();
    tests++;
    if (out_valid !== 1'b1 || sum !== 64'd30) begin
      failed++; $display("FAIL bp_first: ov=%b sum=%h expected ov=1 sum=1e", out_valid, sum);
    end
    for (int i = 0; i < 5; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'(i & 1); in_valid = 1'b1;
      step();
      tests++;
      if ({out_valid, in_ready, cout, ovf, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, 64'd30}) begin
        failed++;
        $display("FAIL bp_hold[%0d]: ov/ir/c/o=%b%b%b%b sum=%h expected 1000 sum=1e", i, out_valid, in_ready, cout, ovf, sum);
      end
    end
    a = 64'd100; b = 64'd1; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      failed++; $display("FAIL b2b_ready: in_ready=%b expected 1", in_ready);
    end
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0) begin
      failed++; $display("FAIL b2b_gap1: out_valid=%b expected 0", out_valid);
    end
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      failed++; $display("FAIL b2b_gap2: out_valid=%b expected 0", out_valid);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || sum !== 64'd101) begin
      failed++; $display("FAIL b2b_result: ov=%b sum=%h expected ov=1 sum=65", out_valid, sum);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] rs, rsn; logic rc, ro, rcn, ron; int lat;
    a = 64'd1; b = 64'd1; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if ({out_valid, in_ready, cout, ovf, sum} !== {1'b0, 1'b1, 1'b0, 1'b0, 64'd0}) begin
      failed++;
      $display("FAIL reset_mid: ov/ir/c/o=%b%b%b%b sum=%h expected 0100 sum=0", out_valid, in_ready, cout, ovf, sum);
    end
    step(); step(); step();
    tests++;
    if (out_valid !== 1'b0) begin
      failed++; $display("FAIL reset_mid_noresult: out_valid=%b expected 0", out_valid);
    end
    run_op(64'd3, 64'd4, 1'b0, rs, rc, ro, rsn, rcn, ron, lat);
    tests++;
    if (rs !== 64'd7 || lat !== 3) begin
      failed++; $display("FAIL after_reset: sum=%h lat=%0d expected sum=7 lat=3", rs, lat);
    end
  endtask

  task automatic test_random();
    logic [65:0] q[$];
    logic [65:0] exp_v;
    logic [64:0] t;
    logic [63:0] bx;
    logic        acc, cons, eo;
    int issued = 0;
    int consumed = 0;
    int cyc = 0;
    in_valid = 1'b0; out_ready = 1'b0;
    while ((issued < 1000 || q.size() != 0) && cyc < 30000) begin
      if (!in_valid && issued < 1000 && $urandom_range(0, 3) != 0) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        case ($urandom_range(0, 7))
          0: b = a;
          1: a = 64'h7FFF_FFFF_FFFF_FFFF;
          2: b = 64'h8000_0000_0000_0000;
          default: ;
        endcase
        sub = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc  = in_valid & in_ready;
      cons = out_valid & out_ready;
      if (cons) begin
        consumed++;
        tests++;
        if (q.size() == 0) begin
          failed++; $display("FAIL rand_dup: result with no pending op, sum=%h", sum);
        end else begin
          exp_v = q.pop_front();
          if ({cout, ovf, sum} !== exp_v) begin
            failed++;
            $display("FAIL rand_result[%0d]: c/o/sum=%b%b %h expected %b%b %h",
                     consumed, cout, ovf, sum, exp_v[65], exp_v[64], exp_v[63:0]);
          end
        end
      end
      if (acc) begin
        bx = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, bx} + {64'd0, sub};
        eo = (a[63] == bx[63]) && (t[63] != a[63]);
        q.push_back({t[64], eo, t[63:0]});
        issued++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    tests++;
    if (issued != 1000 || consumed != 1000 || q.size() != 0) begin
      failed++;
      $display("FAIL rand_count: issued=%0d consumed=%0d pending=%0d expected 1000/1000/0", issued, consumed, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_carry_cross();
    test_overflow();
    test_sub();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
